// File: rtl/prom_pattern_player_if.sv
// PROM read port between the pattern player and its pattern store.
// The player is the master: it owns address, clock enable and write enable.
interface prom_pattern_player_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] AddressA;
  logic                  ClkEn0;
  logic                  WeRenA;
  logic [35:0]           DataOutA;

  modport master (
    output AddressA,
    output ClkEn0,
    output WeRenA,
    input  DataOutA
  );

  modport slave (
    input  AddressA,
    input  ClkEn0,
    input  WeRenA,
    output DataOutA
  );
endinterface

// File: rtl/prom_pattern_player.sv
// Plays LED patterns from a PROM, each word held for its own count.
// Run low freezes the sequence in place; only reset returns to IDLE.
module prom_pattern_player #(
  parameter int ADDR_WIDTH = 8,
  parameter int HOLD_WIDTH = 24
) (
  input  logic                  Clk0,
  input  logic                  AsyncReset0,
  input  logic                  Run,
  prom_pattern_player_if.master prom,
  output logic [7:0]            Led,
  output logic                  Busy,
  output logic                  Wrapped
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0] CNT_ONE  = HOLD_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] nxt_q;
  logic [ADDR_WIDTH-1:0] nxt_d;
  logic [HOLD_WIDTH-1:0] cnt_q;
  logic [HOLD_WIDTH-1:0] cnt_d;
  logic [7:0]            led_q;
  logic [7:0]            led_d;
  logic                  eos_q;
  logic                  eos_d;
  logic                  wrap_q;
  logic                  wrap_d;

  logic [HOLD_WIDTH-1:0] word_hold;
  logic [7:0]            word_led;
  logic                  word_eos;
  logic [ADDR_WIDTH-1:0] word_nxt;
  logic                  at_max;
  logic                  unused_data;

  assign word_hold   = prom.DataOutA[8 +: HOLD_WIDTH];
  assign word_led    = prom.DataOutA[7:0];
  assign word_eos    = prom.DataOutA[35];
  assign at_max      = (addr_q == ADDR_MAX);
  assign unused_data = ^prom.DataOutA;

  // End flag and top-of-PROM both restart at 0, so they share one wrap.
  assign word_nxt = (word_eos || at_max) ? '0
                                         : addr_q + ADDR_ONE;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    eos_d   = eos_q;
    wrap_d  = 1'b0;
    if (Run) begin
      unique case (state_q)
        IDLE: begin
          addr_d  = '0;
          state_d = FETCH;
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          led_d   = word_led;
          cnt_d   = (word_hold == '0) ? '0
                                      : word_hold - CNT_ONE;
          eos_d   = word_eos;
          nxt_d   = word_nxt;
          state_d = HOLD;
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            addr_d  = nxt_q;
            wrap_d  = eos_q || at_max;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk0 or posedge AsyncReset0) begin
    if (AsyncReset0) begin
      state_q <= IDLE;
      addr_q  <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      eos_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      eos_q   <= eos_d;
      wrap_q  <= wrap_d;
    end
  end

  // Enable is gated by Run so a frozen FETCH re-issues on resume.
  assign prom.ClkEn0   = Run && (state_q == FETCH);
  assign prom.AddressA = addr_q;
  assign prom.WeRenA   = 1'b0;

  assign Led     = led_q;
  assign Busy    = (state_q != IDLE);
  assign Wrapped = wrap_q;

endmodule

// File: tb/tb_prom_pattern_player.sv
// Bench for prom_pattern_player: directed scenarios plus a random
// stream checked against a word-schedule model of the player.
`timescale 1ns/1ps
module tb_prom_pattern_player;
  localparam int AW   = 8;
  localparam int HW   = 24;
  localparam int NW   = 2 ** AW;
  localparam int MAXP = 4096;
  localparam int MAXK = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] led;
  logic       busy;
  logic       wrapped;

  prom_pattern_player_if #(.ADDR_WIDTH(AW)) bus ();

  prom_pattern_player #(
    .ADDR_WIDTH(AW),
    .HOLD_WIDTH(HW)
  ) dut (
    .Clk0       (clk),
    .AsyncReset0(rst),
    .Run        (run),
    .prom       (bus.master),
    .Led        (led),
    .Busy       (busy),
    .Wrapped    (wrapped)
  );

  always #5 clk = ~clk;

  logic [35:0] mem [NW];
  always @(posedge clk)
    if (bus.ClkEn0) bus.DataOutA <= mem[bus.AddressA];

  // Expected view indexed by progress = enabled edges since reset.
  logic [7:0] exp_addr  [MAXP];
  logic [7:0] exp_led   [MAXP];
  bit         exp_fetch [MAXP];
  bit         exp_wrap  [MAXP];
  int         fetch_p   [MAXK];
  int         prog;
  logic       adv;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge clk or posedge rst)
    if (rst) begin
      prog <= 0;
      adv  <= 1'b0;
    end else begin
      adv <= run;
      if (run) prog <= prog + 1;
    end

  function automatic logic [35:0] mk(input bit e, input int h,
                                     input logic [7:0] l,
                                     input logic [2:0] junk);
    logic [35:0] w;
    w         = '0;
    w[35]     = e;
    w[34:32]  = junk;
    w[8 +: HW] = HW'(h);
    w[7:0]    = l;
    return w;
  endfunction

  // Word k is fetched at progress p_k and lasts max(H,1)+2 steps.
  task automatic build_model();
    int p = 1;
    int a = 0;
    int k = 0;
    int h;
    int d;
    logic [7:0] prev = 8'h00;
    exp_addr[0]  = '0;
    exp_led[0]   = '0;
    exp_fetch[0] = 1'b0;
    exp_wrap[0]  = 1'b0;
    for (int j = 0; j < MAXK; j++) fetch_p[j] = MAXP;
    while (p < MAXP) begin
      h = int'(mem[a][8 +: HW]);
      d = ((h == 0) ? 1 : h) + 2;
      if (k < MAXK) fetch_p[k] = p;
      for (int i = 0; i < d && p + i < MAXP; i++) begin
        exp_addr[p+i]  = 8'(a);
        exp_led[p+i]   = (i < 2) ? prev : mem[a][7:0];
        exp_fetch[p+i] = (i == 0);
        exp_wrap[p+i]  = (i == 0) && (k > 0) && (a == 0);
      end
      prev = mem[a][7:0];
      a = (mem[a][35] || a == NW - 1) ? 0 : a + 1;
      p += d;
      k++;
    end
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    run = r;
    #1;
  endtask

  task automatic reset_dut();
    run = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_dut(input logic r);
    @(negedge clk);
    rst = 1'b0;
    run = r;
  endtask

  task automatic test_reset();
    reset_dut();
    run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_led: got %h want 00", led);
    end
    n_chk++;
    if (bus.AddressA !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 00", bus.AddressA);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_chk++;
    if (wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrapped: got %b want 0", wrapped);
    end
    n_chk++;
    if (bus.ClkEn0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clken: got %b want 0", bus.ClkEn0);
    end
    n_chk++;
    if (bus.WeRenA !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_weren: got %b want 0", bus.WeRenA);
    end
  endtask

  task automatic test_start_timing();
    logic       ce_w;
    logic [7:0] led_w;
    logic [7:0] addr_w;
    for (int i = 0; i < NW; i++) mem[i] = mk(0, 1, 8'(i), 3'd0);
    mem[0] = mk(0, 3, 8'hA5, 3'b101);
    reset_dut();
    release_dut(1'b1);
    for (int c = 1; c <= 7; c++) begin
      step(1'b1);
      ce_w   = (c == 1) || (c == 6);
      led_w  = (c >= 3) ? 8'hA5 : 8'h00;
      addr_w = (c >= 6) ? 8'd1 : 8'd0;
      n_chk++;
      if (bus.ClkEn0 !== ce_w || led !== led_w ||
          bus.AddressA !== addr_w || wrapped !== 1'b0 ||
          busy !== 1'b1) begin
        n_fail++;
        $display("FAIL start_timing c%0d: ce=%b/%b led=%h/%h addr=%0d/%0d wr=%b busy=%b",
                 c, bus.ClkEn0, ce_w, led, led_w,
                 bus.AddressA, addr_w, wrapped, busy);
      end
    end
  endtask

  task automatic test_zero_hold();
    int n11 = 0;
    int n22 = 0;
    int nce = 0;
    mem[0] = mk(0, 0, 8'h11, 3'd0);
    mem[1] = mk(0, 1, 8'h22, 3'd0);
    mem[2] = mk(0, 5, 8'h33, 3'd0);
    reset_dut();
    release_dut(1'b1);
    for (int c = 1; c <= 12; c++) begin
      step(1'b1);
      if (led === 8'h11) n11++;
      if (led === 8'h22) n22++;
      if (bus.ClkEn0 === 1'b1) nce++;
    end
    n_chk++;
    if (n11 !== 3) begin
      n_fail++;
      $display("FAIL zero_hold_h0: held %0d cycles want 3", n11);
    end
    n_chk++;
    if (n22 !== 3) begin
      n_fail++;
      $display("FAIL zero_hold_h1: held %0d cycles want 3", n22);
    end
    n_chk++;
    if (nce !== 3) begin
      n_fail++;
      $display("FAIL zero_hold_fetches: got %0d want 3", nce);
    end
  endtask

  task automatic test_end_flag();
    int nwr = 0;
    int n99 = 0;
    mem[0] = mk(0, 1, 8'h5A, 3'd0);
    mem[1] = mk(0, 2, 8'h66, 3'd0);
    mem[2] = mk(1, 1, 8'h77, 3'd0);
    mem[3] = mk(0, 1, 8'h99, 3'd0);
    reset_dut();
    release_dut(1'b1);
    for (int c = 1; c <= 30; c++) begin
      step(1'b1);
      if (wrapped === 1'b1) nwr++;
      if (led === 8'h99) n99++;
      if (c == 11) begin
        n_chk++;
        if (wrapped !== 1'b1 || bus.AddressA !== 8'd0 ||
            bus.ClkEn0 !== 1'b1) begin
          n_fail++;
          $display("FAIL end_flag_wrap: wr=%b addr=%0d ce=%b want 1/0/1",
                   wrapped, bus.AddressA, bus.ClkEn0);
        end
      end
      if (c == 12) begin
        n_chk++;
        if (wrapped !== 1'b0) begin
          n_fail++;
          $display("FAIL end_flag_pulse: wr=%b want 0", wrapped);
        end
      end
      if (c == 13) begin
        n_chk++;
        if (led !== 8'h5A) begin
          n_fail++;
          $display("FAIL end_flag_replay: led=%h want 5a", led);
        end
      end
    end
    n_chk++;
    if (nwr !== 2 || n99 !== 0) begin
      n_fail++;
      $display("FAIL end_flag_count: wraps=%0d want 2, word3 seen %0d want 0",
               nwr, n99);
    end
  endtask

  task automatic test_wrap();
    int nwr = 0;
    int i;
    int last;
    for (int j = 0; j < NW; j++)
      mem[j] = mk(0, int'($urandom_range(0, 2)),
                  8'($urandom), 3'($urandom));
    build_model();
    last = fetch_p[NW] + 2;
    reset_dut();
    release_dut(1'b1);
    for (int c = 1; c <= last; c++) begin
      step(1'b1);
      i = (prog < MAXP) ? prog : MAXP - 1;
      if (wrapped === 1'b1) nwr++;
      n_chk++;
      if (bus.AddressA !== exp_addr[i] || led !== exp_led[i] ||
          bus.ClkEn0 !== exp_fetch[i] ||
          wrapped !== exp_wrap[i]) begin
        n_fail++;
        $display("FAIL addr_wrap c%0d: addr=%0d/%0d led=%h/%h ce=%b/%b wr=%b/%b",
                 c, bus.AddressA, exp_addr[i], led, exp_led[i],
                 bus.ClkEn0, exp_fetch[i], wrapped, exp_wrap[i]);
      end
    end
    n_chk++;
    if (nwr !== 1) begin
      n_fail++;
      $display("FAIL addr_wrap_count: got %0d want 1", nwr);
    end
  endtask

  task automatic test_freeze();
    logic r;
    int   nc3 = 0;
    int   nce = 0;
    mem[0] = mk(0, 5, 8'hC3, 3'd0);
    mem[1] = mk(0, 1, 8'h3C, 3'd0);
    reset_dut();
    release_dut(1'b1);
    for (int t = 1; t <= 19; t++) begin
      r = !(t >= 5 && t <= 14);
      step(r);
      if (led === 8'hC3) nc3++;
      if (bus.ClkEn0 === 1'b1) nce++;
      if (!r) begin
        n_chk++;
        if (led !== 8'hC3 || bus.AddressA !== 8'd0 ||
            bus.ClkEn0 !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL freeze_hold t%0d: led=%h addr=%0d ce=%b busy=%b",
                   t, led, bus.AddressA, bus.ClkEn0, busy);
        end
      end
      if (t == 18) begin
        n_chk++;
        if (bus.ClkEn0 !== 1'b1 || bus.AddressA !== 8'd1) begin
          n_fail++;
          $display("FAIL freeze_resume: ce=%b addr=%0d want 1/1",
                   bus.ClkEn0, bus.AddressA);
        end
      end
    end
    n_chk++;
    if (nc3 !== 17 || nce !== 2) begin
      n_fail++;
      $display("FAIL freeze_total: led held %0d want 17, fetches %0d want 2",
               nc3, nce);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    for (int j = 0; j < NW; j++)
      mem[j] = mk(($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 3)),
                  8'($urandom) | 8'h01, 3'($urandom));
    build_model();
    reset_dut();
    release_dut(1'b1);
    step(1'b1);
    while (prog != fetch_p[3] + 1 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    n_chk++;
    if (guard >= 200 || led === 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_reach: prog=%0d led=%h", prog, led);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (led !== 8'h00 || bus.AddressA !== 8'd0 || busy !== 1'b0 ||
        bus.ClkEn0 !== 1'b0 || wrapped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: led=%h addr=%0d busy=%b ce=%b wr=%b",
               led, bus.AddressA, busy, bus.ClkEn0, wrapped);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1);
      n_chk++;
      if (bus.ClkEn0 !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_held: ce=%b busy=%b want 0/0",
                 bus.ClkEn0, busy);
      end
    end
    release_dut(1'b1);
    step(1'b1);
    n_chk++;
    if (bus.ClkEn0 !== 1'b1 || bus.AddressA !== 8'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: ce=%b addr=%0d busy=%b want 1/0/1",
               bus.ClkEn0, bus.AddressA, busy);
    end
  endtask

  task automatic test_random_stream();
    logic r;
    int   i;
    for (int j = 0; j < NW; j++)
      mem[j] = mk(($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 4)),
                  8'($urandom), 3'($urandom));
    build_model();
    reset_dut();
    release_dut(1'($urandom));
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(0, 3) != 0);
      step(r);
      i = (prog < MAXP) ? prog : MAXP - 1;
      n_chk++;
      if (bus.AddressA !== exp_addr[i] || led !== exp_led[i] ||
          bus.ClkEn0 !== (r & exp_fetch[i]) ||
          wrapped !== (adv & exp_wrap[i]) ||
          busy !== (prog > 0) || bus.WeRenA !== 1'b0) begin
        n_fail++;
        $display("FAIL random_stream c%0d p%0d: addr=%0d/%0d led=%h/%h ce=%b wr=%b busy=%b",
                 c, prog, bus.AddressA, exp_addr[i], led, exp_led[i],
                 bus.ClkEn0, wrapped, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_zero_hold();
    test_end_flag();
    test_wrap();
    test_freeze();
    test_reset_mid();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prom_pattern_player.md
PROM_PATTERN_PLAYER -- requirements
Module: prom_pattern_player

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, is the PROM word-address width; AddressA SHALL be this width.
REQ-002 Parameter HOLD_WIDTH, default 24, is the width of the per-word hold-count field and of the internal down-counter.
REQ-003 Clk0  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 AsyncReset0  input  1  asynchronous, active-high reset.
REQ-005 Run  input  1  level enable; high = sequence advances, low = freeze.
REQ-006 DataOutA  input  36  PROM read data, valid the cycle after an enabled address edge.
REQ-007 AddressA  output  ADDR_WIDTH  PROM word address.
REQ-008 ClkEn0  output  1  PROM clock enable.
REQ-009 WeRenA  output  1  PROM write enable; SHALL be constant 0.
REQ-010 Led  output  8  current pattern.
REQ-011 Busy  output  1  high in any state other than IDLE.
REQ-012 Wrapped  output  1  one-cycle pulse when the address returns to 0.

Function
REQ-013 The PROM word format SHALL be:
- [7:0] = LED pattern.
- [8+HOLD_WIDTH-1:8] = hold count H.
- [35] = end-of-sequence flag E.
- All remaining bits are ignored.
REQ-014 The block SHALL use the states IDLE, FETCH, LOAD and HOLD.
REQ-015 IDLE: when Run=1, go to FETCH with AddressA=0; otherwise stay in IDLE.
REQ-016 FETCH: ClkEn0=1 for exactly this cycle; the next state is LOAD.
REQ-017 LOAD: on the edge ending LOAD:
- Led <= DataOutA[7:0].
- counter <= max(H,1)-1; H=0 SHALL be treated as 1.
- E and the next address SHALL be latched.
- The next state is HOLD.
REQ-018 HOLD: if counter != 0, decrement the counter.
REQ-019 HOLD: if counter == 0, load AddressA with the latched next address and go to FETCH.
REQ-020 Timing: Led SHALL change exactly once per word and stay stable for max(H,1)+2 cycles (FETCH + LOAD + HOLD).
REQ-021 Next address SHALL be 0 when E=1 or when AddressA = 2^ADDR_WIDTH-1; otherwise it SHALL be AddressA+1, with no carry beyond ADDR_WIDTH.
REQ-022 Wrapped SHALL pulse high for exactly the one cycle after AddressA is loaded with 0 from HOLD; it SHALL not pulse on the IDLE->FETCH start.
REQ-023 ClkEn0 SHALL be 0 in every state except FETCH.
REQ-024 Run=0 in FETCH, LOAD or HOLD SHALL freeze all state, counter, AddressA and Led, and force ClkEn0=0.
REQ-025 A FETCH frozen by Run=0 SHALL reissue its ClkEn0 pulse on the first cycle after Run returns to 1; Led SHALL not glitch.
REQ-026 The block SHALL never return to IDLE except by reset; Run=0 freezes but does not abort.
REQ-027 When E=1 and the address is already at its maximum on the same word, the next address SHALL be 0 and Wrapped SHALL pulse once, not twice.

Reset
REQ-028 AsyncReset0=1 SHALL immediately force:
- state = IDLE.
- AddressA = 0, Led = 0, counter = 0, latched E = 0.
- Busy = 0, Wrapped = 0, ClkEn0 = 0.
REQ-029 Reset asserted mid-sequence, in any state, SHALL abort with no further ClkEn0 pulse.
REQ-030 After reset release with Run=1, the first FETCH SHALL occur on the first clock edge and use AddressA=0.

Verification
REQ-031 Start/timing: PROM word0 = H=3, Led=0xA5, E=0, Run=1 after reset.
- ClkEn0 pulses in cycle 1.
- Led=0xA5 from cycle 3.
- AddressA=1 and the next ClkEn0 pulse after 5 cycles total.
REQ-032 Zero hold: word with H=0 -> Led is held for exactly 3 cycles, identical to H=1.
REQ-033 End flag: word2 has E=1 -> after its hold, AddressA=0, Wrapped=1 for one cycle, and word0's pattern reappears.
REQ-034 Address wrap: ADDR_WIDTH=8 with all E=0 -> after word 255, AddressA=0 and Wrapped pulses once; AddressA never reaches 256.
REQ-035 Freeze: Run=0 for 10 cycles mid-HOLD with H=5 -> Led, AddressA and counter are unchanged, ClkEn0=0, and the total hold is 5+10 cycles.
REQ-036 Reset mid-operation: AsyncReset0 asserted between clock edges while in LOAD -> outputs are 0 immediately, and after release the restart FETCH uses address 0.
